inst_encoder: RTL and testbench
===============================

# inst_encoder

Streaming LEGv8 instruction encoder: the write-side counterpart of the instruction decoder. It accepts one symbolic instruction per handshake (operation select, register indices, immediate or absolute branch target) and packs it into the 32-bit machine word that the decoder consumes. It tags each word with its instruction-memory byte address from an internal program counter. Words leave through a 2-entry output FIFO with valid/ready, for loading instruction memory from a test host or boot loader.

## Interface
- BASE_ADDR, 32'h0000_0000, PC value after reset; must be word-aligned.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder accepts this cycle; transfer when in_valid && in_ready.
- op_sel  in  4  0 NOP, 1 STUR, 2 LDUR, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 ADDI, 8 SUBI, 9 CBZ, 10 CBNZ, 11 B, 12–15 illegal.
- rd  in  5  Rd/Rt field.
- rn  in  5  Rn field.
- rm  in  5  Rm field (R-format only).
- imm  in  32  D: signed byte offset; I: unsigned immediate; CB/B: absolute byte target.
- pc_load  in  1  load PC from pc_load_val.
- pc_load_val  in  32  new PC; bits [1:0] forced to 0.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head when out_valid && out_ready.
- out_inst  out  32  encoded word.
- out_addr  out  32  byte address of the word.
- out_err  out  1  head word was produced by an encoding error.
- err_count  out  8  saturating error count.

## Operation
- Field layout: Rd/Rt [4:0], Rn [9:5]. Unused fields are 0.
- D (STUR 11111000000, LDUR 11111000010): [31:21] opcode, [20:12] imm[8:0], [11:10] 00. Legal range is −256..255 (signed).
- R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): [20:16] rm, shamt [15:10] = 0.
- I (ADDI 1001000100, SUBI 1101000100): [31:22] opcode, [21:10] imm[11:0]. Legal range is 0..4095.
- CB (CBZ 10110100, CBZ 10110101 for CBNZ): [31:24] opcode, [23:5] off19, [4:0] rd.
  - diff = imm − pc, mod 2^32, interpreted as signed.
  - off = diff >>> 2.
  - Legal: −2^18 ≤ off < 2^18 and imm[1:0] == 0.
- B (000101): [25:0] off26, computed the same way. Legal: −2^25 ≤ off < 2^25.
- NOP (op 0) encodes to 32'h0000_0000.
- Error: illegal op_sel, out-of-range immediate/offset, or misaligned branch target.
  - The word is still emitted, as 32'h0, with out_err = 1.
  - err_count increments by 1 on acceptance and saturates at 255.
- PC:
  - Each accepted instruction uses the current pc as out_addr; pc then advances by 4, wrapping at 2^32.
  - pc_load sets pc = {pc_load_val[31:2], 2'b00}.
  - in_ready is low in any cycle with pc_load = 1, so a load never coincides with an acceptance.
- FIFO:
  - 2 entries, each holding {inst, addr, err}, in order.
  - in_ready = rst_n && !pc_load && (count < 2).
  - Push and pop in the same cycle with count 1 keeps count 1.
  - When count = 2, in_ready is low even if a pop occurs that cycle; there is no pass-through when full.

## Timing
- Reset (asynchronous assert):
  - pc = BASE_ADDR; FIFO count = 0.
  - out_valid = 0, out_inst = 0, out_addr = 0, out_err = 0, err_count = 0.
  - in_ready = 0 while rst_n is low.
- Latency: instruction accepted at edge N appears at the head (out_valid = 1) after edge N when the FIFO was empty. Zero bubbles at full throughput: 1 word/cycle with out_ready held high.
- The head is stable while out_valid && !out_ready. The consumer may hold out_ready low indefinitely.
- pc_load at edge N: the next accepted instruction (edge ≥ N+1) uses the loaded pc. Words already in the FIFO keep their original addresses.
- Reset mid-stream discards FIFO contents and the error count. The first word after release uses BASE_ADDR.
- pc wrap: acceptance at pc 32'hFFFF_FFFC gives the next pc 32'h0. Branch diff uses the same modulo arithmetic.

## Test plan
- Reset, BASE_ADDR 0, out_ready = 1; ADD rd1 rn2 rm3, then ADDI rd9 rn9 imm1 → out_inst 0x8B030041 at addr 0x0, then 0x91000529 at addr 0x4; err 0.
- LDUR rd10 rn1 imm8 → 0xF840802A. STUR imm −256 → [20:12] = 0x100, out_err 0. STUR imm 256 → out_inst 0x0, out_err 1, err_count 1.
- pc_load 0x10 with in_valid high that cycle → in_ready 0. Next cycle CBZ rd0 imm 0x08 → 0xB4FFFFC0 at addr 0x10. Then B imm 0x1014 → 0x14000400 at addr 0x14.
- Backpressure: out_ready = 0, three back-to-back valid inputs → two accepted, in_ready 0 on the third. Raise out_ready → words drain in order with addresses +4 each; third accepted the cycle after count drops to 1.
- Errors:
  - op_sel 13 → 0x0, err 1.
  - ADDI imm 4096 → err.
  - CBNZ imm 0x6 → err (misaligned).
  - Drive 300 error instructions → err_count stays 255.
- Assert rst_n low with 2 words queued → out_valid 0 immediately (asynchronous). After release, next ADD goes to addr BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: bundles the symbolic-instruction input handshake, the PC
// load controls and the encoded-word output handshake of inst_encoder.
//   master : host side (drives instructions, PC loads, consumes words)
//   slave  : encoder side
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [31:0] imm;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, op_sel, rd, rn, rm, imm, pc_load, pc_load_val, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );

  modport slave (
    input  in_valid, op_sel, rd, rn, rm, imm, pc_load, pc_load_val, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: streaming LEGv8 instruction encoder.
// Packs one symbolic instruction per handshake into a 32-bit machine word,
// tags it with the current PC and queues {inst, addr, err} in a 2-entry FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : inst_encoder_if.slave (instruction in, PC load, word out,
//                saturating error count)
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_encoder_if.slave  bus
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_pc;
  logic [7:0]  r_err_cnt;

  logic        w_in_ready;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_diff;
  logic [31:0] w_word;
  logic        w_ok;
  logic [31:0] w_load_pc;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign w_in_ready = rst_n && !bus.pc_load && (r_count != 2'd2);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = (r_count != 2'd0) && bus.out_ready;
  assign w_load_pc  = bus.pc_load_val & 32'hFFFF_FFFC;

  // Branch displacement in modulo-2^32 arithmetic; pc is word aligned so
  // w_diff[1:0] equals the target's low bits (the alignment check).
  assign w_diff = bus.imm - r_pc;

  always_comb begin
    w_word = '0;
    w_ok   = 1'b1;
    case (bus.op_sel)
      4'd0: w_word = '0;
      4'd1, 4'd2: begin
        // signed 9-bit range: bits [31:8] all copies of the sign
        w_ok   = (&bus.imm[31:8]) || !(|bus.imm[31:8]);
        w_word = {(bus.op_sel == 4'd1) ? 11'h7C0 : 11'h7C2,
                  bus.imm[8:0], 2'b00, bus.rn, bus.rd};
      end
      4'd3: w_word = {11'h458, bus.rm, 6'd0, bus.rn, bus.rd};
      4'd4: w_word = {11'h658, bus.rm, 6'd0, bus.rn, bus.rd};
      4'd5: w_word = {11'h450, bus.rm, 6'd0, bus.rn, bus.rd};
      4'd6: w_word = {11'h550, bus.rm, 6'd0, bus.rn, bus.rd};
      4'd7, 4'd8: begin
        w_ok   = !(|bus.imm[31:12]);
        w_word = {(bus.op_sel == 4'd7) ? 10'h244 : 10'h344,
                  bus.imm[11:0], bus.rn, bus.rd};
      end
      4'd9, 4'd10: begin
        // off19 fits iff diff[31:20] is a pure sign extension
        w_ok   = ((&w_diff[31:20]) || !(|w_diff[31:20])) && (w_diff[1:0] == 2'b00);
        w_word = {(bus.op_sel == 4'd9) ? 8'hB4 : 8'hB5, w_diff[20:2], bus.rd};
      end
      4'd11: begin
        w_ok   = ((&w_diff[31:27]) || !(|w_diff[31:27])) && (w_diff[1:0] == 2'b00);
        w_word = {6'b000101, w_diff[27:2]};
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) w_word = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_pc      <= BASE_ADDR;
      r_err_cnt <= 8'd0;
    end else begin
      if (bus.pc_load)
        r_pc <= w_load_pc;
      else if (w_push)
        r_pc <= r_pc + 32'd4;

      if (w_push) begin
        r_mem[r_wr_ptr] <= '{inst: w_word, addr: r_pc, err: !w_ok};
        r_wr_ptr        <= ~r_wr_ptr;
        if (!w_ok && r_err_cnt != 8'hFF)
          r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_inst  = r_mem[r_rd_ptr].inst;
  assign bus.out_addr  = r_mem[r_rd_ptr].addr;
  assign bus.out_err   = r_mem[r_rd_ptr].err;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  inst_encoder_if bus ();

  inst_encoder #(.BASE_ADDR(BASE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc = BASE;
  int          m_err = 0;
  bit          rnd_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: encoding straight from the field tables and ranges.
  function automatic logic [32:0] model(input int op, input logic [4:0] rd, rn, rm,
                                        input logic [31:0] imm, input logic [31:0] pc);
    longint     s_imm, diff, off, w;
    logic [31:0] d;
    bit          ok;
    s_imm = longint'($signed(imm));
    d     = imm - pc;
    diff  = longint'($signed(d));
    off   = diff >>> 2;
    ok    = 1;
    w     = 0;
    case (op)
      0: w = 0;
      1, 2: begin
        ok = (s_imm >= -256) && (s_imm <= 255);
        w  = ((op == 1) ? 64'h7C0 : 64'h7C2) * (2**21) + (s_imm & 511) * 4096
             + longint'(rn) * 32 + longint'(rd);
      end
      3, 4, 5, 6: begin
        case (op)
          3: w = 64'h458; 4: w = 64'h658; 5: w = 64'h450; default: w = 64'h550;
        endcase
        w = w * (2**21) + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
      end
      7, 8: begin
        ok = longint'(imm) <= 4095;
        w  = ((op == 7) ? 64'h244 : 64'h344) * (2**22) + longint'(imm) * 1024
             + longint'(rn) * 32 + longint'(rd);
      end
      9, 10: begin
        ok = (off >= -(2**18)) && (off < 2**18) && (imm % 4 == 0);
        w  = ((op == 9) ? 64'hB4 : 64'hB5) * (2**24) + (off & 64'h7FFFF) * 32 + longint'(rd);
      end
      11: begin
        ok = (off >= -(2**25)) && (off < 2**25) && (imm % 4 == 0);
        w  = 5 * (2**26) + (off & 64'h3FF_FFFF);
      end
      default: ok = 0;
    endcase
    if (!ok) w = 0;
    model = {!ok, w[31:0]};
  endfunction

  // Issue one instruction (caller is just past a rising edge). Expected word
  // comes from the model, or from a given constant when have_k is set.
  task automatic issue(input int op, input logic [4:0] rd, rn, rm, input logic [31:0] imm,
                       input bit have_k, input logic [31:0] k_inst, input logic k_err,
                       output int waits);
    logic [32:0] m;
    bit acc;
    exp_t e;
    m = model(op, rd, rn, rm, imm, m_pc);
    if (have_k) m = {k_err, k_inst};
    bus.in_valid = 1; bus.op_sel = 4'(op); bus.rd = rd; bus.rn = rn; bus.rm = rm; bus.imm = imm;
    acc = 0;
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin acc = 1; break; end
      waits++;
      if (rnd_rdy) begin @(posedge clk); #1 bus.out_ready = 1; end
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance");
      bus.in_valid = 0;
      return;
    end
    e.inst = m[31:0]; e.addr = m_pc; e.err = m[32];
    q.push_back(e);
    m_pc = m_pc + 4;
    if (m[32] && m_err < 255) m_err++;
    @(posedge clk); #1;
    bus.in_valid = 0;
    chk("err_count", 64'(bus.err_count), 64'(m_err));
  endtask

  task automatic send(input int op, input logic [4:0] rd, rn, rm, input logic [31:0] imm);
    int w;
    issue(op, rd, rn, rm, imm, 0, 32'h0, 1'b0, w);
  endtask

  task automatic send_k(input int op, input logic [4:0] rd, rn, rm, input logic [31:0] imm,
                        input logic [31:0] k_inst, input logic k_err);
    int w;
    issue(op, rd, rn, rm, imm, 1, k_inst, k_err, w);
  endtask

  task automatic load_pc(input logic [31:0] v, input bit with_valid);
    bus.pc_load = 1; bus.pc_load_val = v; bus.in_valid = with_valid;
    bus.op_sel = 4'd3;
    @(negedge clk);
    chk("in_ready_on_load", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.pc_load = 0; bus.in_valid = 0;
    m_pc = v & 32'hFFFF_FFFC;
  endtask

  task automatic drain();
    bus.out_ready = 1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a word is handed over.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_word: got %h expected none", bus.out_inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_word", {bus.out_inst, bus.out_addr[30:0], bus.out_err},
            {e.inst, e.addr[30:0], e.err});
        chk("out_addr_msb", 64'(bus.out_addr[31]), 64'(e.addr[31]));
      end
    end
  end

  initial begin
    int w;
    bus.in_valid = 0; bus.op_sel = 0; bus.rd = 0; bus.rn = 0; bus.rm = 0; bus.imm = 0;
    bus.pc_load = 0; bus.pc_load_val = 0; bus.out_ready = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_word", {bus.out_inst, bus.out_addr}, 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Directed vectors
    send_k(3, 5'd1, 5'd2, 5'd3, 32'd0, 32'h8B03_0041, 1'b0);
    send_k(7, 5'd9, 5'd9, 5'd0, 32'd1, 32'h9100_0529, 1'b0);
    send_k(2, 5'd10, 5'd1, 5'd0, 32'd8, 32'hF840_802A, 1'b0);
    send_k(1, 5'd0, 5'd0, 5'd0, -32'sd256, 32'hF810_0000, 1'b0);
    send_k(1, 5'd0, 5'd0, 5'd0, 32'd256, 32'h0, 1'b1);
    chk("err_count_one", 64'(bus.err_count), 64'd1);
    load_pc(32'h10, 1);
    send_k(9, 5'd0, 5'd0, 5'd0, 32'h08, 32'hB4FF_FFC0, 1'b0);
    send_k(11, 5'd0, 5'd0, 5'd0, 32'h1014, 32'h1400_0400, 1'b0);
    send_k(13, 5'd4, 5'd5, 5'd6, 32'h0, 32'h0, 1'b1);
    send_k(7, 5'd1, 5'd1, 5'd0, 32'd4096, 32'h0, 1'b1);
    send_k(10, 5'd1, 5'd0, 5'd0, 32'h6, 32'h0, 1'b1);
    drain();

    // Backpressure: two accepted, third held off until a slot frees
    @(posedge clk); #1 bus.out_ready = 0;
    send(4, 5'd1, 5'd2, 5'd3, 0);
    send(5, 5'd4, 5'd5, 5'd6, 0);
    bus.in_valid = 1; bus.op_sel = 4'd6;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_head_stable", {bus.out_inst, bus.out_addr}, {q[0].inst, q[0].addr});
    end
    @(posedge clk); #1 bus.out_ready = 1;
    issue(6, 5'd7, 5'd8, 5'd9, 0, 0, 32'h0, 1'b0, w);
    chk("bp_third_wait", 64'(w), 64'd1);
    drain();

    // PC wrap and wrapped branch displacement
    load_pc(32'hFFFF_FFFF, 0);
    send(11, 5'd0, 5'd0, 5'd0, 32'h0000_0010);
    send_k(3, 5'd1, 5'd2, 5'd3, 32'd0, 32'h8B03_0041, 1'b0);
    chk("wrap_pc", 64'(q[$].addr), 64'd0);
    drain();

    // Randomized traffic with random backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      int op, sel;
      logic [31:0] imm;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        load_pc(($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFF0, 0);
        continue;
      end
      op  = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      case (sel)
        0: imm = $urandom_range(0, 5000);
        1: imm = $urandom;
        2: imm = m_pc + 32'($signed($urandom_range(0, 4095)) - 2048) * 4 + 32'($urandom_range(0, 1));
        default: begin
          int b;
          b = $urandom_range(0, 7);
          case (b)
            0: imm = -32'sd256; 1: imm = 32'd255; 2: imm = 32'd256; 3: imm = -32'sd257;
            4: imm = 32'd4095; 5: imm = 32'd4096;
            6: imm = m_pc + 32'h0010_0000; default: imm = m_pc - 32'h0010_0000;
          endcase
        end
      endcase
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
    rnd_rdy = 0;
    drain();

    // Error count saturation
    for (int i = 0; i < 300; i++) send(12 + (i % 4), 5'd0, 5'd0, 5'd0, 0);
    chk("err_sat", 64'(bus.err_count), 64'd255);
    drain();

    // Asynchronous reset with two words queued
    @(posedge clk); #1 bus.out_ready = 0;
    send(3, 5'd1, 5'd1, 5'd1, 0);
    send(4, 5'd2, 5'd2, 5'd2, 0);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_err_count", 64'(bus.err_count), 64'd0);
    q.delete();
    m_pc = BASE; m_err = 0;
    @(posedge clk); #1 rst_n = 1; bus.out_ready = 1;
    @(posedge clk); #1;
    send_k(3, 5'd1, 5'd2, 5'd3, 32'd0, 32'h8B03_0041, 1'b0);
    chk("midrst_addr", 64'(q[$].addr), 64'(BASE));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
